// File: rtl/nios2_mul_cell_arbiter_if.sv
// rtl/nios2_mul_cell_arbiter_if.sv - request/response/multiplier-cell bundle for the shared multiplier arbiter
//
// Purpose: groups the two requester channels, the two response channels and the
// 3-cell partial-product multiplier port into one bundle.
// Ports (all logic):
//   req0/1_valid, req0/1_a, req0/1_b   requester -> arbiter
//   req0/1_ready                        arbiter -> requester
//   resp0/1_valid, resp0/1_result       arbiter -> requester
//   resp0/1_ready                       requester -> arbiter
//   mul_src1, mul_src2, mul_en          arbiter -> cell
//   mul_p1, mul_p2, mul_p3              cell -> arbiter
//   busy                                arbiter status
// Modports: slave = arbiter view, master = requester/cell side view.
interface nios2_mul_cell_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic        resp0_valid;
  logic        resp0_ready;
  logic [31:0] resp0_result;
  logic        resp1_valid;
  logic        resp1_ready;
  logic [31:0] resp1_result;
  logic [31:0] mul_src1;
  logic [31:0] mul_src2;
  logic        mul_en;
  logic [31:0] mul_p1;
  logic [31:0] mul_p2;
  logic [31:0] mul_p3;
  logic        busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    input  resp0_ready, resp1_ready, mul_p1, mul_p2, mul_p3,
    output req0_ready, req1_ready, resp0_valid, resp0_result,
    output resp1_valid, resp1_result, mul_src1, mul_src2, mul_en, busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    output resp0_ready, resp1_ready, mul_p1, mul_p2, mul_p3,
    input  req0_ready, req1_ready, resp0_valid, resp0_result,
    input  resp1_valid, resp1_result, mul_src1, mul_src2, mul_en, busy
  );
endinterface

// File: rtl/nios2_mul_cell_arbiter.sv
// rtl/nios2_mul_cell_arbiter.sv - shares one 3-cell 16x16 partial-product multiplier between two requesters
//
// Purpose: accepts 32x32 multiply requests from two requesters, drives the
// operands into the shared cell, sums the partial products into the low 32 bits
// of the product and returns it to the owning requester.
// Ports:
//   clk      single clock, all state on posedge
//   reset_n  asynchronous active-low reset
//   bus      slave side of nios2_mul_cell_arbiter_if (requests, responses,
//            multiplier cell port, busy)
// Parameter:
//   RR_ENABLE  1 = round-robin on contention, 0 = requester 0 always wins
module nios2_mul_cell_arbiter #(
  parameter bit RR_ENABLE = 1'b1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  nios2_mul_cell_arbiter_if.slave        bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_SUM  = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic [31:0] src1_q, src1_d;
  logic [31:0] src2_q, src2_d;
  logic [31:0] result_q, result_d;
  logic        grant;

  // Winner of the IDLE arbitration; only meaningful when some valid is high.
  always_comb begin
    grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant = RR_ENABLE ? ~last_q : 1'b0;
    end else if (bus.req1_valid) begin
      grant = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;   // requester 0 wins the first contention
      src1_q   <= 32'd0;
      src2_q   <= 32'd0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    last_d          = last_q;
    src1_d          = src1_q;
    src2_d          = src2_q;
    result_d        = result_q;
    bus.req0_ready  = 1'b0;
    bus.req1_ready  = 1'b0;
    bus.resp0_valid = 1'b0;
    bus.resp1_valid = 1'b0;
    bus.mul_en      = 1'b0;
    bus.busy        = 1'b1;
    case (state_q)
      S_IDLE: begin
        bus.busy       = 1'b0;
        bus.req0_ready = bus.req0_valid && !grant;
        bus.req1_ready = bus.req1_valid && grant;
        if (bus.req0_ready || bus.req1_ready) begin
          owner_d = grant;
          last_d  = grant;
          src1_d  = grant ? bus.req1_a : bus.req0_a;
          src2_d  = grant ? bus.req1_b : bus.req0_b;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        // The cell captures its products at the end of this cycle only, so its
        // outputs stay frozen from SUM onward.
        bus.mul_en = 1'b1;
        state_d    = S_SUM;
      end
      S_SUM: begin
        // Cross terms only reach bits 31:16; carries beyond bit 31 are dropped.
        result_d = bus.mul_p1 + ((bus.mul_p2 + bus.mul_p3) << 16);
        state_d  = S_RESP;
      end
      S_RESP: begin
        bus.resp0_valid = !owner_q;
        bus.resp1_valid = owner_q;
        if (owner_q ? bus.resp1_ready : bus.resp0_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.mul_src1     = src1_q;
  assign bus.mul_src2     = src2_q;
  assign bus.resp0_result = result_q;
  assign bus.resp1_result = result_q;

endmodule

// File: tb/tb_nios2_mul_cell_arbiter.sv
// tb/tb_nios2_mul_cell_arbiter.sv - self-checking bench for nios2_mul_cell_arbiter
module tb_nios2_mul_cell_arbiter;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int          hold;
  } op_t;

  logic clk;
  logic reset_n;
  int   cyc;
  int   checks;
  int   errors;

  // Per-DUT (index 0: round-robin, index 1: fixed priority) and per-requester signals.
  logic        v     [2][2];
  logic [31:0] a     [2][2];
  logic [31:0] b     [2][2];
  logic        rr    [2][2];
  logic        rdy   [2][2];
  logic        rv    [2][2];
  logic [31:0] res   [2][2];
  logic        men   [2];
  logic        bsy   [2];
  logic [31:0] src1  [2];
  logic [31:0] src2  [2];
  logic [31:0] p1    [2];
  logic [31:0] p2    [2];
  logic [31:0] p3    [2];

  op_t         qs [2][$];
  int          last_m [2];
  int          glog [$];
  int          acc_cyc [$];
  logic [31:0] last_res;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    nios2_mul_cell_arbiter_if bus ();

    nios2_mul_cell_arbiter #(.RR_ENABLE(k == 0 ? 1'b1 : 1'b0)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
    );

    assign bus.req0_valid  = v[k][0];
    assign bus.req0_a      = a[k][0];
    assign bus.req0_b      = b[k][0];
    assign bus.req1_valid  = v[k][1];
    assign bus.req1_a      = a[k][1];
    assign bus.req1_b      = b[k][1];
    assign bus.resp0_ready = rr[k][0];
    assign bus.resp1_ready = rr[k][1];
    assign rdy[k][0]       = bus.req0_ready;
    assign rdy[k][1]       = bus.req1_ready;
    assign rv[k][0]        = bus.resp0_valid;
    assign rv[k][1]        = bus.resp1_valid;
    assign res[k][0]       = bus.resp0_result;
    assign res[k][1]       = bus.resp1_result;
    assign men[k]          = bus.mul_en;
    assign bsy[k]          = bus.busy;
    assign src1[k]         = bus.mul_src1;
    assign src2[k]         = bus.mul_src2;
    assign p1[k]           = bus.mul_p1;
    assign p2[k]           = bus.mul_p2;
    assign p3[k]           = bus.mul_p3;

    // Behavioural 3-cell multiplier: one enabled register stage.
    initial begin
      bus.mul_p1 = 32'd0;
      bus.mul_p2 = 32'd0;
      bus.mul_p3 = 32'd0;
    end
    always @(posedge clk) begin
      if (bus.mul_en) begin
        bus.mul_p1 <= 32'(bus.mul_src1[15:0])  * 32'(bus.mul_src2[15:0]);
        bus.mul_p2 <= 32'(bus.mul_src1[15:0])  * 32'(bus.mul_src2[31:16]);
        bus.mul_p3 <= 32'(bus.mul_src1[31:16]) * 32'(bus.mul_src2[15:0]);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic add(input int r, input logic [31:0] ai, input logic [31:0] bi, input int hold);
    op_t o;
    o.a = ai;
    o.b = bi;
    o.hold = hold;
    qs[r].push_back(o);
  endtask

  task automatic idle_all();
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 2; r++) begin
        v[k][r]  = 1'b0;
        a[k][r]  = 32'd0;
        b[k][r]  = 32'd0;
        rr[k][r] = 1'b0;
      end
    end
  endtask

  // Plays both requesters of DUT k from the queues and checks every cycle
  // against the arbitration/latency rules. Called at posedge+1.
  task automatic run(input int k, input int budget);
    int          start;
    bit          out;
    int          own;
    int          tacc;
    int          hold;
    int          win;
    bit          done;
    logic [31:0] ea, eb, ep, x1, x2, x3;
    start = cyc;
    out = 0; own = 0; tacc = 0; hold = 0; ea = 0; eb = 0;
    glog.delete();
    acc_cyc.delete();
    while ((qs[0].size() > 0 || qs[1].size() > 0 || out) && (cyc - start) < budget) begin
      for (int r = 0; r < 2; r++) begin
        v[k][r] = (qs[r].size() > 0);
        a[k][r] = (qs[r].size() > 0) ? qs[r][0].a : 32'd0;
        b[k][r] = (qs[r].size() > 0) ? qs[r][0].b : 32'd0;
        rr[k][r] = out ? (cyc >= tacc + 3 + hold) : 1'b1;
      end
      @(negedge clk);
      ep = ea * eb;
      chk("busy", bsy[k], out);
      chk("mul_en", men[k], out && (cyc == tacc + 1));
      if (out && cyc == tacc + 2) begin
        x1 = 32'(ea[15:0]) * 32'(eb[15:0]);
        x2 = 32'(ea[15:0]) * 32'(eb[31:16]);
        x3 = 32'(ea[31:16]) * 32'(eb[15:0]);
        chk("cell_p1", p1[k], x1);
        chk("cell_p2", p2[k], x2);
        chk("cell_p3", p3[k], x3);
      end
      for (int r = 0; r < 2; r++) begin
        chk("resp_valid", rv[k][r], out && (r == own) && (cyc >= tacc + 3));
      end
      if (out && cyc >= tacc + 3) chk("resp_result", res[k][own], ep);
      win = -1;
      if (!out) begin
        if (v[k][0] && v[k][1]) win = (k == 0) ? ((last_m[k] == 0) ? 1 : 0) : 0;
        else if (v[k][0]) win = 0;
        else if (v[k][1]) win = 1;
      end
      for (int r = 0; r < 2; r++) chk("req_ready", rdy[k][r], r == win);
      done = out && (cyc >= tacc + 3) && rr[k][own];
      if (done) begin
        out = 0;
        last_res = res[k][own];
      end
      if (win >= 0) begin
        ea = qs[win][0].a;
        eb = qs[win][0].b;
        hold = qs[win][0].hold;
        void'(qs[win].pop_front());
        out = 1;
        own = win;
        tacc = cyc;
        last_m[k] = win;
        glog.push_back(win);
        acc_cyc.push_back(cyc);
      end
      @(posedge clk);
      #1;
    end
    chk("run_complete", qs[0].size() + qs[1].size() + int'(out), 0);
    qs[0].delete();
    qs[1].delete();
    idle_all();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    last_res = 32'd0;
    idle_all();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_busy", bsy[k], 0);
      chk("rst_mul_en", men[k], 0);
      chk("rst_src1", src1[k], 0);
      chk("rst_src2", src2[k], 0);
      chk("rst_result", res[k][0], 0);
      for (int r = 0; r < 2; r++) begin
        chk("rst_ready", rdy[k][r], 0);
        chk("rst_resp_valid", rv[k][r], 0);
      end
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    last_m[0] = 1;
    last_m[1] = 1;

    // Contention, round-robin: grants alternate starting with requester 0.
    for (int i = 0; i < 3; i++) begin
      add(0, $urandom, $urandom, 0);
      add(1, $urandom, $urandom, 0);
    end
    run(0, 500);
    chk("rr_grant_count", glog.size(), 6);
    for (int i = 0; i < glog.size(); i++) chk("rr_grant_order", glog[i], i % 2);

    // Contention, fixed priority: all requester-0 ops first.
    for (int i = 0; i < 3; i++) begin
      add(0, $urandom, $urandom, 0);
      add(1, $urandom, $urandom, 0);
    end
    run(1, 500);
    chk("fp_grant_count", glog.size(), 6);
    for (int i = 0; i < glog.size(); i++) chk("fp_grant_order", glog[i], (i < 3) ? 0 : 1);

    // Single op on requester 0.
    add(0, 32'h0003_0002, 32'h0005_0004, 0);
    run(0, 100);
    chk("single_result", last_res, 32'h0016_0008);

    // Wraparound on requester 1.
    add(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run(0, 100);
    chk("wrap_p1", p1[0], 32'hFFFE_0001);
    chk("wrap_p2", p2[0], 32'hFFFE_0001);
    chk("wrap_p3", p3[0], 32'hFFFE_0001);
    chk("wrap_result", last_res, 32'h0000_0001);

    // Backpressure: resp0_ready low for 5 cycles while req1 waits.
    add(0, $urandom, $urandom, 5);
    add(1, $urandom, $urandom, 0);
    run(0, 100);
    chk("bp_first_grant", glog[0], 0);
    chk("bp_req1_accept", acc_cyc[1] - acc_cyc[0], 9);

    // Random traffic with random response stalls on both DUTs.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) begin
        add(0, $urandom, $urandom, $urandom_range(0, 3));
        add(1, $urandom, $urandom, $urandom_range(0, 3));
      end
      run(k, 1000);
    end

    // Reset during SUM aborts the operation.
    a[0][0] = 32'h1234_5678;
    b[0][0] = 32'h9ABC_DEF0;
    v[0][0] = 1'b1;
    rr[0][0] = 1'b1;
    @(negedge clk);
    chk("abort_accept", rdy[0][0], 1);
    @(posedge clk);
    #1;
    v[0][0] = 1'b0;
    @(negedge clk);
    chk("abort_mul_en", men[0], 1);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort_busy", bsy[0], 0);
    chk("abort_mul_en_rst", men[0], 0);
    chk("abort_src1", src1[0], 0);
    chk("abort_src2", src2[0], 0);
    chk("abort_result", res[0][0], 0);
    for (int r = 0; r < 2; r++) chk("abort_ready", rdy[0][r], 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_resp0", rv[0][0], 0);
      chk("abort_no_resp1", rv[0][1], 0);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    last_m[0] = 1;
    last_m[1] = 1;
    @(negedge clk);
    chk("abort_still_idle", rv[0][0], 0);
    @(posedge clk);
    #1;
    add(0, 32'd7, 32'd6, 0);
    run(0, 100);
    chk("post_reset_result", last_res, 32'd42);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
